ctrl_pipe: RTL and testbench

Pipelined control-path carrier and hazard unit for the five-stage core. Takes the decode-stage control bundle, register indices and use flags from the combinational decoder. Registers them through the EX, MEM and WB stages, and generates the stall, bubble and forwarding selects. Parametrised for forwarding or interlock-only operation and for register-file write-through, so one block serves every pipeline variant.

---
 rtl/ctrl_pipe.sv | 121 ++++++++++++
 tb/tb_ctrl_pipe.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_pipe.sv
// Control-path carrier for the five-stage core: EX/MEM/WB control registers,
// RAW hazard interlock, EX operand forwarding selects and stall/flush counters.
module ctrl_pipe #(
   parameter int DWIDTH    = 32,
   parameter int CTRLW     = 12,
   parameter int FWD_EN    = 1,
   parameter int RF_BYPASS = 0,
   parameter int CNTW      = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              id_valid_i,
   input  logic [DWIDTH-1:0] id_insn_i,
   input  logic [CTRLW-1:0]  id_ctrl_i,
   input  logic [4:0]        id_rs1_i,
   input  logic [4:0]        id_rs2_i,
   input  logic [4:0]        id_rd_i,
   input  logic              id_use_rs1_i,
   input  logic              id_use_rs2_i,
   input  logic              ex_redirect_i,
   output logic              stall_o,
   output logic              kill_id_o,
   output logic              ex_valid_o,
   output logic              mem_valid_o,
   output logic              wb_valid_o,
   output logic [CTRLW-1:0]  ex_ctrl_o,
   output logic [CTRLW-1:0]  mem_ctrl_o,
   output logic [CTRLW-1:0]  wb_ctrl_o,
   output logic [4:0]        ex_rd_o,
   output logic [4:0]        mem_rd_o,
   output logic [4:0]        wb_rd_o,
   output logic [DWIDTH-1:0] ex_insn_o,
   output logic [1:0]        fwd_a_o,
   output logic [1:0]        fwd_b_o,
   output logic [CNTW-1:0]   stall_cnt_o,
   output logic [CNTW-1:0]   flush_cnt_o
);

   logic              r_ex_v, r_mem_v, r_wb_v;
   logic [CTRLW-1:0]  r_ex_ctrl, r_mem_ctrl, r_wb_ctrl;
   logic [4:0]        r_ex_rd, r_mem_rd, r_wb_rd;
   logic [4:0]        r_ex_rs1, r_ex_rs2;
   logic              r_ex_u1, r_ex_u2;
   logic [DWIDTH-1:0] r_ex_insn;
   logic [CNTW-1:0]   r_stall_cnt, r_flush_cnt;

   logic w_hit_ex, w_hit_mem, w_hit_wb, w_haz, w_stall, w_load;

   // A producer in a stage hits a consumer operand when it really writes a
   // nonzero register that the consumer really reads.
   function automatic logic f_hit(input logic v, input logic wr, input logic [4:0] rd,
                                  input logic [4:0] rs, input logic use_f);
      return v & wr & (rd != 5'd0) & use_f & (rd == rs);
   endfunction

   function automatic logic [1:0] f_sel(input logic [4:0] rs, input logic use_f);
      logic [1:0] sel;
      sel = 2'b00;
      if (FWD_EN != 0 && use_f && rs != 5'd0) begin
         if (f_hit(r_mem_v, r_mem_ctrl[0], r_mem_rd, rs, use_f))     sel = 2'b10;
         else if (f_hit(r_wb_v, r_wb_ctrl[0], r_wb_rd, rs, use_f))   sel = 2'b01;
      end
      return sel;
   endfunction

   always_comb begin
      w_hit_ex  = f_hit(r_ex_v,  r_ex_ctrl[0],  r_ex_rd,  id_rs1_i, id_use_rs1_i) |
                  f_hit(r_ex_v,  r_ex_ctrl[0],  r_ex_rd,  id_rs2_i, id_use_rs2_i);
      w_hit_mem = f_hit(r_mem_v, r_mem_ctrl[0], r_mem_rd, id_rs1_i, id_use_rs1_i) |
                  f_hit(r_mem_v, r_mem_ctrl[0], r_mem_rd, id_rs2_i, id_use_rs2_i);
      w_hit_wb  = f_hit(r_wb_v,  r_wb_ctrl[0],  r_wb_rd,  id_rs1_i, id_use_rs1_i) |
                  f_hit(r_wb_v,  r_wb_ctrl[0],  r_wb_rd,  id_rs2_i, id_use_rs2_i);
      // With forwarding only a load in EX is too late; otherwise every
      // in-flight producer blocks until the RF holds the value.
      if (FWD_EN != 0) w_haz = w_hit_ex & r_ex_ctrl[1];
      else             w_haz = w_hit_ex | w_hit_mem | ((RF_BYPASS == 0) & w_hit_wb);
      w_stall = id_valid_i & w_haz & ~ex_redirect_i;
      w_load  = id_valid_i & ~ex_redirect_i & ~w_stall;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_ex_v <= 1'b0; r_ex_ctrl <= '0; r_ex_rd <= '0; r_ex_insn <= '0;
         r_ex_rs1 <= '0; r_ex_rs2 <= '0; r_ex_u1 <= 1'b0; r_ex_u2 <= 1'b0;
         r_mem_v <= 1'b0; r_mem_ctrl <= '0; r_mem_rd <= '0;
         r_wb_v <= 1'b0; r_wb_ctrl <= '0; r_wb_rd <= '0;
         r_stall_cnt <= '0; r_flush_cnt <= '0;
      end else begin
         r_mem_v <= r_ex_v;  r_mem_ctrl <= r_ex_ctrl;  r_mem_rd <= r_ex_rd;
         r_wb_v  <= r_mem_v; r_wb_ctrl  <= r_mem_ctrl; r_wb_rd  <= r_mem_rd;
         if (w_load) begin
            r_ex_v <= 1'b1; r_ex_ctrl <= id_ctrl_i; r_ex_rd <= id_rd_i; r_ex_insn <= id_insn_i;
            r_ex_rs1 <= id_rs1_i; r_ex_rs2 <= id_rs2_i;
            r_ex_u1 <= id_use_rs1_i; r_ex_u2 <= id_use_rs2_i;
         end else begin
            r_ex_v <= 1'b0; r_ex_ctrl <= '0; r_ex_rd <= '0; r_ex_insn <= '0;
            r_ex_rs1 <= '0; r_ex_rs2 <= '0; r_ex_u1 <= 1'b0; r_ex_u2 <= 1'b0;
         end
         if (w_stall && r_stall_cnt != '1)       r_stall_cnt <= r_stall_cnt + CNTW'(1);
         if (ex_redirect_i && r_flush_cnt != '1) r_flush_cnt <= r_flush_cnt + CNTW'(1);
      end
   end

   assign stall_o     = w_stall;
   assign kill_id_o   = ex_redirect_i;
   assign ex_valid_o  = r_ex_v;
   assign mem_valid_o = r_mem_v;
   assign wb_valid_o  = r_wb_v;
   assign ex_ctrl_o   = r_ex_ctrl;
   assign mem_ctrl_o  = r_mem_ctrl;
   assign wb_ctrl_o   = r_wb_ctrl;
   assign ex_rd_o     = r_ex_rd;
   assign mem_rd_o    = r_mem_rd;
   assign wb_rd_o     = r_wb_rd;
   assign ex_insn_o   = r_ex_insn;
   assign fwd_a_o     = f_sel(r_ex_rs1, r_ex_u1);
   assign fwd_b_o     = f_sel(r_ex_rs2, r_ex_u2);
   assign stall_cnt_o = r_stall_cnt;
   assign flush_cnt_o = r_flush_cnt;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Bench for ctrl_pipe: four configurations share one stimulus stream and are
// checked every cycle against an in-flight instruction model.
module tb_ctrl_pipe;

   // dut 0: fwd, 1: interlock, 2: interlock + RF bypass, 3: fwd with 4-bit counters
   logic clk, reset;
   logic id_valid, redirect, u1, u2;
   logic [31:0] insn;
   logic [11:0] ctrl;
   logic [4:0]  rd, rs1, rs2;

   logic [3:0]        stall, kill, exv, memv, wbv;
   logic [3:0][11:0]  exc, memc, wbc;
   logic [3:0][4:0]   exrd, memrd, wbrd;
   logic [3:0][31:0]  exinsn, sc, fc;
   logic [3:0][1:0]   fa, fb;

   int checks = 0;
   int failures = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      ctrl_pipe #(.DWIDTH(32), .CTRLW(12), .FWD_EN((g == 0) ? 1 : 0),
                  .RF_BYPASS((g == 2) ? 1 : 0), .CNTW(32)) u_dut (
         .clk(clk), .reset(reset), .id_valid_i(id_valid), .id_insn_i(insn),
         .id_ctrl_i(ctrl), .id_rs1_i(rs1), .id_rs2_i(rs2), .id_rd_i(rd),
         .id_use_rs1_i(u1), .id_use_rs2_i(u2), .ex_redirect_i(redirect),
         .stall_o(stall[g]), .kill_id_o(kill[g]),
         .ex_valid_o(exv[g]), .mem_valid_o(memv[g]), .wb_valid_o(wbv[g]),
         .ex_ctrl_o(exc[g]), .mem_ctrl_o(memc[g]), .wb_ctrl_o(wbc[g]),
         .ex_rd_o(exrd[g]), .mem_rd_o(memrd[g]), .wb_rd_o(wbrd[g]),
         .ex_insn_o(exinsn[g]), .fwd_a_o(fa[g]), .fwd_b_o(fb[g]),
         .stall_cnt_o(sc[g]), .flush_cnt_o(fc[g]));
   end

   ctrl_pipe #(.DWIDTH(32), .CTRLW(12), .FWD_EN(1), .RF_BYPASS(0), .CNTW(4)) u_dut3 (
      .clk(clk), .reset(reset), .id_valid_i(id_valid), .id_insn_i(insn),
      .id_ctrl_i(ctrl), .id_rs1_i(rs1), .id_rs2_i(rs2), .id_rd_i(rd),
      .id_use_rs1_i(u1), .id_use_rs2_i(u2), .ex_redirect_i(redirect),
      .stall_o(stall[3]), .kill_id_o(kill[3]),
      .ex_valid_o(exv[3]), .mem_valid_o(memv[3]), .wb_valid_o(wbv[3]),
      .ex_ctrl_o(exc[3]), .mem_ctrl_o(memc[3]), .wb_ctrl_o(wbc[3]),
      .ex_rd_o(exrd[3]), .mem_rd_o(memrd[3]), .wb_rd_o(wbrd[3]),
      .ex_insn_o(exinsn[3]), .fwd_a_o(fa[3]), .fwd_b_o(fb[3]),
      .stall_cnt_o(sc[3][3:0]), .flush_cnt_o(fc[3][3:0]));
   assign sc[3][31:4] = '0;
   assign fc[3][31:4] = '0;

   // ---------------- model: one in-flight instruction record per stage ----------------
   typedef struct packed {
      logic        v;
      logic [11:0] ctrl;
      logic [4:0]  rd, rs1, rs2;
      logic        u1, u2;
      logic [31:0] insn;
   } ent_t;

   ent_t        m [4][3];   // [dut][0=EX,1=MEM,2=WB]
   logic [31:0] sc_m [4];
   logic [31:0] fc_m [4];

   function automatic bit fwd_of(int d); return (d == 0 || d == 3); endfunction
   function automatic bit byp_of(int d); return (d == 2); endfunction
   function automatic logic [31:0] cmax(int d); return (d == 3) ? 32'd15 : 32'hFFFF_FFFF; endfunction

   function automatic bit writes(ent_t e, logic [4:0] r);
      return e.v && e.ctrl[0] && e.rd != 5'd0 && e.rd == r;
   endfunction

   // Instruction k+1 places ahead of ID produces r: is it still unusable?
   function automatic bit blocked(int d, logic [4:0] r);
      for (int k = 0; k < 3; k++)
         if (writes(m[d][k], r)) begin
            if (fwd_of(d)) begin
               if (k == 0 && m[d][k].ctrl[1]) return 1'b1;
            end else if (k < (byp_of(d) ? 2 : 3)) return 1'b1;
         end
      return 1'b0;
   endfunction

   function automatic bit exp_stall(int d);
      if (!id_valid || redirect) return 1'b0;
      return (u1 && blocked(d, rs1)) || (u2 && blocked(d, rs2));
   endfunction

   function automatic logic [1:0] exp_fwd(int d, logic [4:0] r, logic u);
      if (!fwd_of(d) || !m[d][0].v || !u || r == 5'd0) return 2'b00;
      if (writes(m[d][1], r)) return 2'b10;
      if (writes(m[d][2], r)) return 2'b01;
      return 2'b00;
   endfunction

   function automatic ent_t id_ent();
      ent_t e;
      e.v = 1'b1; e.ctrl = ctrl; e.rd = rd; e.rs1 = rs1; e.rs2 = rs2;
      e.u1 = u1; e.u2 = u2; e.insn = insn;
      return e;
   endfunction

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int d = 0; d < 4; d++) begin
            for (int k = 0; k < 3; k++) m[d][k] <= '0;
            sc_m[d] <= '0;
            fc_m[d] <= '0;
         end
      end else begin
         for (int d = 0; d < 4; d++) begin
            m[d][2] <= m[d][1];
            m[d][1] <= m[d][0];
            m[d][0] <= (!id_valid || redirect || exp_stall(d)) ? '0 : id_ent();
            if (exp_stall(d) && sc_m[d] != cmax(d)) sc_m[d] <= sc_m[d] + 32'd1;
            if (redirect && fc_m[d] != cmax(d))     fc_m[d] <= fc_m[d] + 32'd1;
         end
      end
   end

   task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s dut%0d at %0t: got %h expected %h", nm, d, $time, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!reset) begin
         for (int d = 0; d < 4; d++) begin
            chk("stall",    d, 32'(stall[d]),  32'(exp_stall(d)));
            chk("kill",     d, 32'(kill[d]),   32'(redirect));
            chk("ex_valid", d, 32'(exv[d]),    32'(m[d][0].v));
            chk("ex_ctrl",  d, 32'(exc[d]),    32'(m[d][0].ctrl));
            chk("ex_rd",    d, 32'(exrd[d]),   32'(m[d][0].rd));
            chk("ex_insn",  d, exinsn[d],      m[d][0].insn);
            chk("mem_valid",d, 32'(memv[d]),   32'(m[d][1].v));
            chk("mem_ctrl", d, 32'(memc[d]),   32'(m[d][1].ctrl));
            chk("mem_rd",   d, 32'(memrd[d]),  32'(m[d][1].rd));
            chk("wb_valid", d, 32'(wbv[d]),    32'(m[d][2].v));
            chk("wb_ctrl",  d, 32'(wbc[d]),    32'(m[d][2].ctrl));
            chk("wb_rd",    d, 32'(wbrd[d]),   32'(m[d][2].rd));
            chk("fwd_a",    d, 32'(fa[d]),     32'(exp_fwd(d, m[d][0].rs1, m[d][0].u1)));
            chk("fwd_b",    d, 32'(fb[d]),     32'(exp_fwd(d, m[d][0].rs2, m[d][0].u2)));
            chk("stall_cnt",d, sc[d],          sc_m[d]);
            chk("flush_cnt",d, fc[d],          fc_m[d]);
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic drv(input logic v, input logic [11:0] c, input logic [4:0] d_rd,
                      input logic [4:0] a, input logic ua, input logic [4:0] b,
                      input logic ub, input logic rdr);
      id_valid = v; ctrl = c; rd = d_rd; rs1 = a; u1 = ua; rs2 = b; u2 = ub;
      redirect = rdr; insn = $urandom;
   endtask

   task automatic idle(); drv(1'b0, 12'h0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0); endtask
   task automatic cyc(); @(posedge clk); #1; endtask
   task automatic do_reset(); idle(); reset = 1'b1; cyc(); reset = 1'b0; endtask

   int nst [4];

   initial begin
      reset = 1'b0;
      idle();
      #1 reset = 1'b1;
      cyc(); cyc();
      reset = 1'b0;

      // mid-stream reset with three instructions in flight
      drv(1'b0, 12'h0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1); cyc();
      drv(1'b1, 12'h001, 5'd10, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0); cyc();
      drv(1'b1, 12'h001, 5'd11, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0); cyc();
      drv(1'b1, 12'h001, 5'd12, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0); cyc();
      drv(1'b1, 12'h001, 5'd13, 5'd10, 1'b1, 5'd11, 1'b1, 1'b0);
      #1 chk("pre_rst_wb_valid", 0, 32'(wbv[0]), 32'd1);
      chk("pre_rst_flush", 0, fc[0], 32'd1);
      #1 reset = 1'b1;
      #1;
      for (int d = 0; d < 4; d++) begin
         chk("rst_valids", d, 32'({exv[d], memv[d], wbv[d]}), 32'd0);
         chk("rst_cnts", d, sc[d] | fc[d], 32'd0);
         chk("rst_stall", d, 32'(stall[d]), 32'd0);
      end
      idle(); cyc(); reset = 1'b0;

      // load-use with forwarding
      do_reset();
      drv(1'b1, 12'h003, 5'd5, 5'd1, 1'b1, 5'd0, 1'b0, 1'b0); cyc();
      drv(1'b1, 12'h001, 5'd6, 5'd5, 1'b1, 5'd1, 1'b1, 1'b0);
      #1 chk("lu_stall", 0, 32'(stall[0]), 32'd1); cyc();
      #1 chk("lu_stall2", 0, 32'(stall[0]), 32'd0);
      chk("lu_bubble", 0, 32'(exv[0]), 32'd0); cyc();
      idle();
      #1 chk("lu_ex_rd", 0, 32'(exrd[0]), 32'd6);
      chk("lu_fwd_a", 0, 32'(fa[0]), 32'd1);
      chk("lu_cnt", 0, sc[0], 32'd1);

      // ALU producer: MEM then WB forwarding
      do_reset();
      drv(1'b1, 12'h001, 5'd7, 5'd1, 1'b1, 5'd0, 1'b0, 1'b0); cyc();
      drv(1'b1, 12'h001, 5'd8, 5'd1, 1'b1, 5'd7, 1'b1, 1'b0);
      #1 chk("alu_stall", 0, 32'(stall[0]), 32'd0); cyc();
      drv(1'b1, 12'h001, 5'd9, 5'd7, 1'b1, 5'd0, 1'b0, 1'b0);
      #1 chk("alu_ex_rd", 0, 32'(exrd[0]), 32'd8);
      chk("alu_fwd_b", 0, 32'(fb[0]), 32'd2); cyc();
      idle();
      #1 chk("alu3_ex_rd", 0, 32'(exrd[0]), 32'd9);
      chk("alu3_fwd_a", 0, 32'(fa[0]), 32'd1);

      // interlock depth per configuration
      do_reset();
      drv(1'b1, 12'h001, 5'd3, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0); cyc();
      drv(1'b1, 12'h001, 5'd4, 5'd3, 1'b1, 5'd0, 1'b0, 1'b0);
      for (int d = 0; d < 4; d++) nst[d] = 0;
      repeat (5) begin
         #1 for (int d = 0; d < 4; d++) nst[d] += int'(stall[d]);
         cyc();
      end
      idle();
      chk("il_stalls_fwd", 0, 32'(nst[0]), 32'd0);
      chk("il_stalls_nobyp", 1, 32'(nst[1]), 32'd3);
      chk("il_stalls_byp", 2, 32'(nst[2]), 32'd2);
      #1 chk("il_cnt_nobyp", 1, sc[1], 32'd3);

      // x0 never creates a dependency
      do_reset();
      drv(1'b1, 12'h001, 5'd0, 5'd1, 1'b1, 5'd0, 1'b0, 1'b0); cyc();
      drv(1'b1, 12'h001, 5'd6, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0);
      #1 for (int d = 0; d < 4; d++) chk("x0_stall", d, 32'(stall[d]), 32'd0);
      cyc(); idle();
      #1 for (int d = 0; d < 2; d++) chk("x0_fwd", d, 32'({fa[d], fb[d]}), 32'd0);

      // redirect overrides a load-use stall
      do_reset();
      drv(1'b1, 12'h003, 5'd5, 5'd1, 1'b1, 5'd0, 1'b0, 1'b0); cyc();
      drv(1'b1, 12'h001, 5'd6, 5'd5, 1'b1, 5'd1, 1'b1, 1'b1);
      #1 chk("rd_stall", 0, 32'(stall[0]), 32'd0);
      chk("rd_kill", 0, 32'(kill[0]), 32'd1); cyc();
      idle();
      #1 chk("rd_bubble", 0, 32'(exv[0]), 32'd0);
      chk("rd_flush", 0, fc[0], 32'd1);
      chk("rd_scnt", 0, sc[0], 32'd0);

      // 20 load-use stalls: 4-bit counter saturates
      do_reset();
      repeat (20) begin
         drv(1'b1, 12'h003, 5'd5, 5'd1, 1'b1, 5'd0, 1'b0, 1'b0); cyc();
         drv(1'b1, 12'h001, 5'd6, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0); cyc();
      end
      idle();
      #1 chk("sat_cnt32", 0, sc[0], 32'd20);
      chk("sat_cnt4", 3, sc[3], 32'd15);

      // randomized traffic, small register range for dense hazards
      do_reset();
      repeat (800) begin
         drv(1'($urandom_range(0, 3) != 0), 12'($urandom), 5'($urandom_range(0, 3)),
             5'($urandom_range(0, 3)), 1'($urandom), 5'($urandom_range(0, 3)),
             1'($urandom), 1'($urandom_range(0, 7) == 0));
         cyc();
      end
      idle(); cyc();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
